// File: rtl/at_load_queue_pkg.sv
// Shared constants and helpers for the at load queue.
// Defines default widths, the pointer/count width function and the queue operation encoding.
package at_load_queue_pkg;

    localparam int AT_DATA_SIZE = 8;
    localparam int AT_LQ_DEPTH  = 4;

    // Ceiling log2, evaluated at elaboration time to size pointers and the count.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        LQ_IDLE = 2'b00,
        LQ_POP  = 2'b01,
        LQ_PUSH = 2'b10,
        LQ_BOTH = 2'b11
    } lq_op_e;

endpackage

// File: rtl/at_load_queue_ctl.sv
// Pointer, occupancy and handshake control for the at load queue.
// Optional empty-queue bypass decode is enabled by AT_LOAD_QUEUE_BYPASS_EN.
module at_load_queue_ctl
    import at_load_queue_pkg::*;
#(
    parameter int DEPTH = AT_LQ_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    take,
    output logic                    in_ready,
    output logic [clog2(DEPTH):0]   count,
    output logic                    empty,
    output logic                    full,
    output logic                    wr_en,
    output logic                    rd_en,
    output logic                    byp_en,
    output logic [clog2(DEPTH)-1:0] wr_addr,
    output logic [clog2(DEPTH)-1:0] rd_addr
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    lq_op_e        op;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;

`ifdef AT_LOAD_QUEUE_BYPASS_EN
    assign byp_en = empty && push && take;
`else
    assign byp_en = 1'b0;
`endif

    assign wr_en   = push && !byp_en;
    assign rd_en   = take && !empty;
    assign wr_addr = wptr_q;
    assign rd_addr = rptr_q;
    assign count   = count_q;
    assign op      = lq_op_e'({wr_en, rd_en});

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) wptr_d = wptr_q + AW'(1);
        if (rd_en) rptr_d = rptr_q + AW'(1);
        case (op)
            LQ_PUSH: count_d = count_q + CW'(1);
            LQ_POP:  count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/at_load_queue.sv
// Buffered feeder in front of the at holding register: FIFO storage plus registered e/d load stage.
// Define AT_LOAD_QUEUE_BYPASS_EN to forward a word straight through an empty queue.
module at_load_queue
    import at_load_queue_pkg::*;
#(
    parameter int SIZE  = AT_DATA_SIZE,
    parameter int DEPTH = AT_LQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [SIZE-1:0]       in_data,
    output logic                  in_ready,
    input  logic                  take,
    output logic                  e,
    output logic [SIZE-1:0]       d,
    output logic [clog2(DEPTH):0] count,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = clog2(DEPTH);

    logic [SIZE-1:0] mem_q [DEPTH];
    logic            wr_en, rd_en, byp_en;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic            e_q, e_d;
    logic [SIZE-1:0] d_q, d_d;

    at_load_queue_ctl #(.DEPTH(DEPTH)) u_ctl (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .take     (take),
        .in_ready (in_ready),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .byp_en   (byp_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr)
    );

    // NOTE: the storage array is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= in_data;
    end

    always_comb begin
        e_d = 1'b0;
        d_d = d_q;
        if (byp_en) begin
            e_d = 1'b1;
            d_d = in_data;
        end else if (rd_en) begin
            e_d = 1'b1;
            d_d = mem_q[rd_addr];
        end
    end

    // Reset has priority, so a pop sampled together with reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= 1'b0;
            d_q <= '0;
        end else begin
            e_q <= e_d;
            d_q <= d_d;
        end
    end

    assign e = e_q;
    assign d = d_q;

endmodule

// File: tb/tb_at_load_queue.sv
// Scoreboard bench for at_load_queue (SIZE=8, DEPTH=4): directed stimulus pushes expected words,
// a negedge monitor pops and compares whenever e is asserted.
module tb_at_load_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       take;
    logic       e;
    logic [7:0] d;
    logic [2:0] count;
    logic       empty;
    logic       full;

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    logic [7:0] exp_q [$];

    at_load_queue dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .take     (take),
        .e        (e),
        .d        (d),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every e pulse must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (e === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_e: d=%0h with no word expected at %0t", d, $time);
            end else begin
                check("d_order", 32'(d), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int p0;
        logic [7:0] fill [5];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44; fill[4] = 8'h55;

        // 1. Reset with active inputs
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h77; take = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_e", 32'(e), 32'd0);
            check("rst_d", 32'(d), 32'h00);
            check("rst_count", 32'(count), 32'd0);
            check("rst_empty", 32'(empty), 32'd1);
            check("rst_full", 32'(full), 32'd0);
        end
        reset = 1'b0; in_valid = 1'b0; take = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_e", 32'(e), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);

        // 2. Fill to full; fifth word refused
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = fill[i];
            step();
        end
        in_valid = 1'b0;
        check("fill_count", 32'(count), 32'd4);
        check("fill_full", 32'(full), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_empty", 32'(empty), 32'd0);
        check("fill_no_e", 32'(e), 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(fill[i]);

        // 3. Drain: four consecutive pulses then idle
        p0 = pulses;
        take = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("drain_e", 32'(e), (i < 4) ? 32'd1 : 32'd0);
        end
        take = 1'b0;
        step();
        check("drain_pulses", 32'(pulses - p0), 32'd4);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // 4. Streaming with simultaneous push/pop across pointer wrap
        p0 = pulses;
        for (int i = 1; i <= 10; i++) exp_q.push_back(8'(i));
        in_valid = 1'b1; in_data = 8'h01; take = 1'b0;
        step();
        check("stream_first_count", 32'(count), 32'd1);
        for (int i = 2; i <= 10; i++) begin
            in_data = 8'(i); take = 1'b1;
            step();
            check("stream_count", 32'(count), 32'd1);
            check("stream_e", 32'(e), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_last_e", 32'(e), 32'd1);
        check("stream_end_count", 32'(count), 32'd0);
        take = 1'b0;
        step();
        check("stream_pulses", 32'(pulses - p0), 32'd10);

        // 5. Reset while a pop is requested
        in_valid = 1'b1; in_data = 8'hA0;
        step();
        in_data = 8'hB0;
        step();
        in_valid = 1'b0;
        check("mid_count_before", 32'(count), 32'd2);
        take = 1'b1; reset = 1'b1;
        step();
        check("mid_rst_e", 32'(e), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_d", 32'(d), 32'h00);
        reset = 1'b0;
        step();
        take = 1'b0;
        check("mid_after_e", 32'(e), 32'd0);
        check("mid_after_empty", 32'(empty), 32'd1);
        step();
        check("mid_after_e2", 32'(e), 32'd0);

        // 6. Push and take together into an empty queue
        in_valid = 1'b1; in_data = 8'h5A; take = 1'b1;
`ifdef AT_LOAD_QUEUE_BYPASS_EN
        exp_q.push_back(8'h5A);
        step();
        in_valid = 1'b0; take = 1'b0;
        check("byp_e", 32'(e), 32'd1);
        check("byp_count", 32'(count), 32'd0);
        step();
        check("byp_e_off", 32'(e), 32'd0);
`else
        step();
        in_valid = 1'b0; take = 1'b0;
        check("nobyp_e", 32'(e), 32'd0);
        check("nobyp_count", 32'(count), 32'd1);
        exp_q.push_back(8'h5A);
        take = 1'b1;
        step();
        take = 1'b0;
        check("nobyp_e_late", 32'(e), 32'd1);
        check("nobyp_count_after", 32'(count), 32'd0);
        step();
        check("nobyp_e_off", 32'(e), 32'd0);
`endif

        step();
        step();
        check("outstanding_words", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/at_load_queue.md
Name: at_load_queue

Overview:
- Buffered feeder stage sitting directly upstream of the enabled holding register in the at datapath.
- Accepts words from the producer with a valid/ready handshake.
- Stores up to DEPTH words in order.
- When the consumer requests a word, issues a one-cycle load-enable pulse plus data that drive the holding register's e/d inputs.

Parameters:
- SIZE, 8: data word width; matches the downstream holding register width.
- DEPTH, 4: queue entries; power of two, minimum 2.
- CW, log2(DEPTH)+1: width of the count output; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  SIZE  producer word.
- in_ready  output  1  queue can accept; a push occurs when in_valid & in_ready.
- take  input  1  consumer requests the next word.
- e  output  1  load-enable pulse to the downstream register.
- d  output  SIZE  word qualified by e.
- count  output  CW  occupied entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values (while reset is high, and on the following cycle):
  - e=0, d=0, count=0, empty=1, full=0, in_ready=0.
  - Read and write pointers = 0.
  - in_ready rises on the first cycle after reset deasserts.
- Storage: DEPTH x SIZE register array with circular read/write pointers of log2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0.
- in_ready = !full && !reset, decoded from the registered count. No combinational path from take to in_ready.
- Push (in_valid & in_ready): in_data is written at wptr; wptr increments.
- Pop (take & !empty, at cycle N):
  - Cycle N+1: e=1 and d = mem[rptr sampled at N]; rptr increments.
  - Otherwise e=0 on the next cycle and d holds its last value.
  - e is never asserted for more than one cycle per pop.
- take while empty: ignored, e=0 next cycle, no state change, no error.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When full, in_ready=0, so only the pop happens and count decrements.
  - When empty, only the push happens (pop not honoured) and count increments.
- count arithmetic: +1 on push only, -1 on pop only, unchanged otherwise. count never exceeds DEPTH or drops below 0.
- Latency (without bypass): minimum 2 cycles from push to e (push at N, take at N+1, e at N+2). In steady state, one word per cycle.
- Reset mid-operation: all contents discarded. A pending e is cancelled; e=0 in the cycle after reset is sampled.
- Ordering: strict FIFO. Data is never reordered, duplicated or dropped.

Optional Feature:
- Macro: AT_LOAD_QUEUE_BYPASS_EN.
- Defined: when empty=1 and in_valid & in_ready & take in the same cycle N:
  - in_data is forwarded directly, giving e=1, d=in_data at N+1.
  - No entry is written; pointers and count are unchanged.
  - Minimum latency drops to 1 cycle.
- Not defined: no bypass path. The word is enqueued and the take in that cycle is ignored, because empty is sampled.

Decomposition:
- Shared header/package:
  - AT_DATA_SIZE default (8) and AT_LQ_DEPTH default (4).
  - log2 constant function used to derive pointer and count widths.
- One natural sub-module: at_load_queue_ctl.
  - Owns the pointers, count, full/empty and in_ready.
  - Emits wr_en, rd_en, wr_addr and rd_addr.
- The top level holds the storage array and the registered e/d output stage.

Test Plan (SIZE=8, DEPTH=4):
1. Reset behaviour: hold reset for 3 cycles with in_valid=1 and take=1 -> in_ready=0, e=0, d=0x00, count=0, empty=1 throughout; after release, in_ready=1 on the next cycle.
2. Fill and backpressure: push 0x11, 0x22, 0x33, 0x44 with take=0 -> count=4, full=1, in_ready=0; a fifth word 0x55 is not accepted.
3. Drain in order: from full, take=1 for 5 cycles -> e pulses on 4 consecutive cycles with d = 0x11, 0x22, 0x33, 0x44; the fifth cycle gives e=0; empty=1, count=0.
4. Wrap-around and simultaneous push/pop: stream 10 words 0x01..0x0A with take=1 every cycle after the first push -> d sequence is 0x01..0x0A with no gaps; count stays 1; pointers wrap twice.
5. Mid-operation reset: queue holds 0xA0, 0xB0; take=1 and reset=1 in the same cycle -> e=0 on the next cycle, count=0, and 0xA0 never appears on d.
6. Bypass: push 0x5A with take=1 into an empty queue in the same cycle.
   - With AT_LOAD_QUEUE_BYPASS_EN: e=1, d=0x5A on the next cycle, count stays 0.
   - Without it: count=1 and e=0; a take on the following cycle yields e=1, d=0x5A.
